// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states,
// opcodes, instruction classes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    typedef enum logic [3:0] {
        C_ALU  = 4'd0,
        C_LW   = 4'd1,
        C_SW   = 4'd2,
        C_BEQ  = 4'd3,
        C_BNE  = 4'd4,
        C_BLTZ = 4'd5,
        C_J    = 4'd6,
        C_JR   = 4'd7,
        C_JAL  = 4'd8,
        C_HALT = 4'd9,
        C_ILL  = 4'd10
    } iclass_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] PCS_NEXT   = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JR     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static datapath
// selects that hold for the whole life of an instruction.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op,
    output logic [3:0]         cls,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               extSel,
    output logic               aluSrcA,
    output logic               aluSrcB,
    output logic [1:0]         regDst
);

    always_comb begin
        cls     = C_ILL;
        aluOp   = ALUOP_W'(ALU_ADD);
        extSel  = 1'b0;
        aluSrcA = 1'b0;
        aluSrcB = 1'b0;
        regDst  = RD_RA;
        case (op)
            OP_ADD:   begin cls = C_ALU; regDst = RD_RD; end
            OP_SUB:   begin cls = C_ALU; regDst = RD_RD; aluOp = ALUOP_W'(ALU_SUB); end
            OP_AND:   begin cls = C_ALU; regDst = RD_RD; aluOp = ALUOP_W'(ALU_AND); end
            OP_SLT:   begin cls = C_ALU; regDst = RD_RD; aluOp = ALUOP_W'(ALU_SLT); end
            OP_SLL:   begin cls = C_ALU; regDst = RD_RD; aluOp = ALUOP_W'(ALU_SLL); aluSrcA = 1'b1; end
            OP_ADDIU: begin cls = C_ALU; regDst = RD_RT; aluSrcB = 1'b1; extSel = 1'b1; end
            OP_SLTI:  begin cls = C_ALU; regDst = RD_RT; aluSrcB = 1'b1; extSel = 1'b1; aluOp = ALUOP_W'(ALU_SLT); end
            OP_ANDI:  begin cls = C_ALU; regDst = RD_RT; aluSrcB = 1'b1; aluOp = ALUOP_W'(ALU_AND); end
            OP_ORI:   begin cls = C_ALU; regDst = RD_RT; aluSrcB = 1'b1; aluOp = ALUOP_W'(ALU_OR); end
            OP_XORI:  begin cls = C_ALU; regDst = RD_RT; aluSrcB = 1'b1; aluOp = ALUOP_W'(ALU_XOR); end
            OP_LW:    begin cls = C_LW; regDst = RD_RT; aluSrcB = 1'b1; extSel = 1'b1; end
            OP_SW:    begin cls = C_SW; aluSrcB = 1'b1; extSel = 1'b1; end
            OP_BEQ:   begin cls = C_BEQ;  extSel = 1'b1; aluOp = ALUOP_W'(ALU_SUB); end
            OP_BNE:   begin cls = C_BNE;  extSel = 1'b1; aluOp = ALUOP_W'(ALU_SUB); end
            OP_BLTZ:  begin cls = C_BLTZ; extSel = 1'b1; aluOp = ALUOP_W'(ALU_SUB); end
            OP_J:     cls = C_J;
            OP_JR:    cls = C_JR;
            OP_JAL:   cls = C_JAL;
            OP_HALT:  cls = C_HALT;
            default:  cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle CPU: IF/ID/EXE/MEM/WB sequencing,
// opcode latch and registered write/memory strobes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               sign,
    output logic [2:0]         state,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               InsMemRW,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic               ExtSel,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Illegal
);

    state_t              cur, nxt;
    logic [OP_W-1:0]     opReg;
    logic [3:0]          clsBits;
    iclass_t             cls;
    logic [ALUOP_W-1:0]  decAluOp;
    logic                decExtSel, decSrcA, decSrcB;
    logic [1:0]          decRegDst;
    logic                brTaken;

    ctrl_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_decode (
        .op      (opReg),
        .cls     (clsBits),
        .aluOp   (decAluOp),
        .extSel  (decExtSel),
        .aluSrcA (decSrcA),
        .aluSrcB (decSrcB),
        .regDst  (decRegDst)
    );

    assign cls   = iclass_t'(clsBits);
    assign state = cur;

    always_comb begin
        brTaken = 1'b0;
        case (cls)
            C_BEQ:   brTaken = zero;
            C_BNE:   brTaken = ~zero;
            C_BLTZ:  brTaken = sign;
            default: brTaken = 1'b0;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                case (cls)
                    C_ALU:               nxt = S_EXE_AL;
                    C_LW, C_SW:          nxt = S_EXE_LS;
                    C_BEQ, C_BNE, C_BLTZ: nxt = S_EXE_BR;
                    C_HALT:              nxt = S_ID;
                    default:             nxt = S_IF;
                endcase
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL:  nxt = S_IF;
            S_EXE_LS: nxt = S_MEM;
            S_MEM:    nxt = (cls == C_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  nxt = S_IF;
            S_EXE_BR: nxt = S_IF;
            default:  nxt = S_IF;
        endcase
    end

    // jal writes $31 in ID, before opReg holds it, so decode the raw op at the IF edge
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cur    <= S_IF;
            opReg  <= '0;
            RegWre <= 1'b0;
            mRD    <= 1'b0;
            mWR    <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_IF)
                opReg <= op;
            RegWre <= (nxt == S_WB_AL) || (nxt == S_WB_LD) ||
                      ((cur == S_IF) && (op == OP_JAL));
            mRD    <= (nxt == S_MEM) && (cls == C_LW);
            mWR    <= (nxt == S_MEM) && (cls == C_SW);
        end
    end

    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = PCS_NEXT;
        Illegal   = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        ALUOp     = '0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        RegDst    = RD_RA;
        IRWre     = RST_n && (cur == S_IF);
        InsMemRW  = RST_n;
        if (cur != S_IF) begin
            ALUOp   = decAluOp;
            ExtSel  = decExtSel;
            ALUSrcA = decSrcA;
            ALUSrcB = decSrcB;
            RegDst  = decRegDst;
        end
        case (cur)
            S_ID: begin
                case (cls)
                    C_J, C_JAL: begin PCWre = 1'b1; PCSrc = PCS_JUMP; end
                    C_JR:       begin PCWre = 1'b1; PCSrc = PCS_JR; end
                    C_ILL:      begin PCWre = 1'b1; Illegal = 1'b1; end
                    default:    PCWre = 1'b0;
                endcase
            end
            S_WB_AL: begin PCWre = 1'b1; WrRegDSrc = 1'b1; end
            S_WB_LD: begin PCWre = 1'b1; WrRegDSrc = 1'b1; DBDataSrc = 1'b1; end
            S_MEM:    PCWre = (cls == C_SW);
            S_EXE_BR: begin
                PCWre = 1'b1;
                PCSrc = brTaken ? PCS_BRANCH : PCS_NEXT;
            end
            default: PCWre = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues one expected
// output vector per cycle, the monitor compares on every falling edge.
module tb_multicycle_ctrl;

    logic       CLK;
    logic       RST_n;
    logic [5:0] opIn;
    logic       zero, sign;
    logic [2:0] state;
    logic       PCWre, IRWre, RegWre, InsMemRW, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, Illegal;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int errors = 0;
    int checks = 0;

    logic [21:0] expQ[$];
    string       tagQ[$];
    logic [21:0] actVec;

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(3)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .op        (opIn),
        .zero      (zero),
        .sign      (sign),
        .state     (state),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .InsMemRW  (InsMemRW),
        .mRD       (mRD),
        .mWR       (mWR),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .DBDataSrc (DBDataSrc),
        .WrRegDSrc (WrRegDSrc),
        .RegDst    (RegDst),
        .ExtSel    (ExtSel),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp),
        .Illegal   (Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {state, PCWre,IRWre,RegWre,InsMemRW,mRD,mWR,DBDataSrc,WrRegDSrc, RegDst, PCSrc, ALUOp, ExtSel,ALUSrcA,ALUSrcB,Illegal}
    assign actVec = {state, PCWre, IRWre, RegWre, InsMemRW, mRD, mWR, DBDataSrc, WrRegDSrc,
                     RegDst, PCSrc, ALUOp, ExtSel, ALUSrcA, ALUSrcB, Illegal};

    function automatic logic [21:0] mk(input logic [2:0] st, input logic [7:0] strb,
                                       input logic [1:0] rdst, input logic [1:0] pcs,
                                       input logic [2:0] aop, input logic [3:0] sel);
        return {st, strb, rdst, pcs, aop, sel};
    endfunction

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            logic [21:0] e;
            string       t;
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checks++;
            if (actVec !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", t, actVec, e, $time);
            end
        end
    end

    task automatic push(input string tag, input logic [21:0] v);
        expQ.push_back(v);
        tagQ.push_back(tag);
    endtask

    // Drive op during IF, then scramble it so the latch is exercised.
    task automatic issue(input logic [5:0] o, input logic z, input logic s, input int unsigned n);
        opIn = o; zero = z; sign = s;
        @(posedge CLK); #1;
        opIn = 6'b101010;
        for (int unsigned i = 1; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic pushIF(input string tag);
        push({tag, ".IF"}, mk(3'd0, 8'b0101_0000, 2'b00, 2'b00, 3'b000, 4'b0000));
    endtask

    task automatic doReset();
        RST_n = 1'b0;
        push("reset", mk(3'd0, 8'b0000_0000, 2'b00, 2'b00, 3'b000, 4'b0000));
        @(negedge CLK);
        @(posedge CLK); #1;
        RST_n = 1'b1;
    endtask

    task automatic runAlu(input string tag, input logic [5:0] o, input logic [1:0] rdst,
                          input logic [2:0] aop, input logic [3:0] sel);
        pushIF(tag);
        push({tag, ".ID"},  mk(3'd1, 8'b0001_0000, rdst, 2'b00, aop, sel));
        push({tag, ".EXE"}, mk(3'd6, 8'b0001_0000, rdst, 2'b00, aop, sel));
        push({tag, ".WB"},  mk(3'd7, 8'b1011_0001, rdst, 2'b00, aop, sel));
        issue(o, 1'b0, 1'b0, 4);
    endtask

    task automatic runMem(input string tag, input logic isLoad);
        logic [1:0] rdst;
        rdst = isLoad ? 2'b01 : 2'b00;
        pushIF(tag);
        push({tag, ".ID"},  mk(3'd1, 8'b0001_0000, rdst, 2'b00, 3'b000, 4'b1010));
        push({tag, ".EXE"}, mk(3'd2, 8'b0001_0000, rdst, 2'b00, 3'b000, 4'b1010));
        if (isLoad) begin
            push({tag, ".MEM"}, mk(3'd3, 8'b0001_1000, rdst, 2'b00, 3'b000, 4'b1010));
            push({tag, ".WB"},  mk(3'd4, 8'b1011_0011, rdst, 2'b00, 3'b000, 4'b1010));
            issue(6'b110001, 1'b0, 1'b0, 5);
        end else begin
            push({tag, ".MEM"}, mk(3'd3, 8'b1001_0100, rdst, 2'b00, 3'b000, 4'b1010));
            issue(6'b110000, 1'b0, 1'b0, 4);
        end
    endtask

    task automatic runBr(input string tag, input logic [5:0] o, input logic z, input logic s,
                         input logic taken);
        pushIF(tag);
        push({tag, ".ID"}, mk(3'd1, 8'b0001_0000, 2'b00, 2'b00, 3'b001, 4'b1000));
        push({tag, ".BR"}, mk(3'd5, 8'b1001_0000, 2'b00, taken ? 2'b01 : 2'b00, 3'b001, 4'b1000));
        issue(o, z, s, 3);
    endtask

    task automatic runJmp(input string tag, input logic [5:0] o, input logic rgw,
                          input logic [1:0] pcs, input logic ill);
        pushIF(tag);
        push({tag, ".ID"}, mk(3'd1, {1'b1, 1'b0, rgw, 1'b1, 4'b0000}, 2'b00, pcs, 3'b000,
                              {3'b000, ill}));
        issue(o, 1'b0, 1'b0, 2);
    endtask

    initial begin
        RST_n = 1'b1; opIn = '0; zero = 1'b0; sign = 1'b0;
        #2;
        doReset();

        runAlu("add",   6'b000000, 2'b10, 3'b000, 4'b0000);
        runAlu("sub",   6'b000001, 2'b10, 3'b001, 4'b0000);
        runAlu("ori",   6'b010010, 2'b01, 3'b011, 4'b0010);
        runAlu("xori",  6'b010011, 2'b01, 3'b111, 4'b0010);
        runAlu("addiu", 6'b000010, 2'b01, 3'b000, 4'b1010);
        runAlu("sll",   6'b011000, 2'b10, 3'b010, 4'b0100);
        runAlu("slt",   6'b100111, 2'b10, 3'b110, 4'b0000);
        runAlu("andi",  6'b010001, 2'b01, 3'b100, 4'b0010);
        runMem("lw", 1'b1);
        runMem("sw", 1'b0);
        runBr("beqT",  6'b110100, 1'b1, 1'b0, 1'b1);
        runBr("beqN",  6'b110100, 1'b0, 1'b0, 1'b0);
        runBr("bneT",  6'b110101, 1'b0, 1'b0, 1'b1);
        runBr("bneN",  6'b110101, 1'b1, 1'b0, 1'b0);
        runBr("bltzT", 6'b110110, 1'b0, 1'b1, 1'b1);
        runBr("bltzN", 6'b110110, 1'b1, 1'b0, 1'b0);
        runJmp("jal", 6'b111010, 1'b1, 2'b11, 1'b0);
        runJmp("j",   6'b111000, 1'b0, 2'b11, 1'b0);
        runJmp("jr",  6'b111001, 1'b0, 2'b10, 1'b0);
        runJmp("ill", 6'b101010, 1'b0, 2'b00, 1'b1);

        // abort an add while it sits in WB_AL
        pushIF("addRst");
        push("addRst.ID",  mk(3'd1, 8'b0001_0000, 2'b10, 2'b00, 3'b000, 4'b0000));
        push("addRst.EXE", mk(3'd6, 8'b0001_0000, 2'b10, 2'b00, 3'b000, 4'b0000));
        push("addRst.WB",  mk(3'd7, 8'b1011_0001, 2'b10, 2'b00, 3'b000, 4'b0000));
        issue(6'b000000, 1'b0, 1'b0, 3);
        @(negedge CLK); #1;
        doReset();
        runAlu("addPost", 6'b000000, 2'b10, 3'b000, 4'b0000);

        pushIF("halt");
        for (int i = 0; i < 20; i++)
            push("halt.ID", mk(3'd1, 8'b0001_0000, 2'b00, 2'b00, 3'b000, 4'b0000));
        issue(6'b111111, 1'b0, 1'b0, 21);
        doReset();
        runMem("lwPost", 1'b1);

        repeat (3) @(posedge CLK);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath enable, including the register file write enable `RegWre`, the PC/IR write enables, memory strobes and mux selects.
- Takes the IR opcode plus the ALU `zero`/`sign` flags and sits between the instruction register and the datapath.
- The register file write port depends on the glitch-free `RegWre` pulse defined here.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALU operation code width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- op  in  6  opcode field IR[31:26], stable from end of IF.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- state  out  3  current FSM state.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction register load enable.
- RegWre  out  1  register file write enable, flop-driven.
- InsMemRW  out  1  instruction memory read (1 = read).
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- ALUSrcA  out  1  0 = rs, 1 = shamt.
- ALUSrcB  out  1  0 = rt, 1 = extended imm.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB.
- RegDst  out  2  write register select: 00 = $31, 01 = rt, 10 = rd.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jr, 11 = j/jal.
- ALUOp  out  3  ALU function.
- Illegal  out  1  one-cycle pulse in ID on an undefined opcode.

Behaviour:
- Reset (RST_n low, asynchronous):
  - state = IF (000).
  - PCWre, IRWre, RegWre, mRD, mWR, Illegal = 0; PCSrc = 00; all other outputs = 0.
  - Any in-flight instruction is aborted with no register or memory write.
  - InsMemRW = 1 from the first cycle after release.
- States: IF = 000, ID = 001, EXE_LS = 010, MEM = 011, WB_LD = 100, EXE_BR = 101, EXE_AL = 110, WB_AL = 111.
- Opcodes:
  - R/I ALU: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bne 110101, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - halt 111111.
- Transitions:
  - IF always goes to ID. IRWre = 1 in IF only.
  - From ID:
    - ALU ops go to EXE_AL → WB_AL → IF.
    - lw/sw go to EXE_LS → MEM. From MEM, lw goes to WB_LD → IF; sw goes to IF.
    - Branches go to EXE_BR → IF.
    - j, jr, jal go from ID to IF.
    - halt stays in ID permanently (PCWre = 0) until reset.
    - Undefined opcode: ID → IF, PCWre = 1 (PC+4), Illegal = 1.
- Latency in cycles: ALU 4, lw 5, sw 4, branch 3, jump 2.
- PCWre:
  - Asserted exactly in the final state of each instruction: WB_AL, WB_LD, MEM (sw), EXE_BR, ID (j/jr/jal/illegal).
  - Asserted in no other cycle.
- RegWre:
  - Asserted only in WB_AL, WB_LD, and ID for jal (RegDst = 00, WrRegDSrc = 0).
  - Generated as a register loaded from the next-state decode. It must be glitch-free and must never go high outside those states, because the register file treats the RegWre edge as a write strobe.
  - Never asserted for sw, branches, j, jr, halt or illegal opcodes.
- Memory strobes: mRD = 1 in MEM for lw only; mWR = 1 in MEM for sw only. mRD and mWR are never high together.
- Branch resolution in EXE_BR:
  - PCSrc = 01 when taken, else 00.
  - Taken conditions: beq when zero = 1; bne when zero = 0; bltz when sign = 1.
  - ALUOp = subtract.
- Selects:
  - ExtSel = 1 for addiu, slti, lw, sw and branches; 0 for andi, ori, xori.
  - ALUSrcA = 1 for sll only.
  - ALUSrcB = 1 for I-type ALU ops and lw/sw.
  - DBDataSrc = 1 in WB_LD only.
- op is latched when leaving IF. Later changes on the op input do not affect the instruction in flight.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - ALUOp codes (add 000, sub 001, sll 010, or 011, and 100, slt 110, xor 111);
  - PCSrc and RegDst encodings.
- One sub-module, ctrl_decode: purely combinational, maps latched op to instruction class and static selects (ALUOp, ExtSel, ALUSrcA/B, RegDst).
- multicycle_ctrl holds the FSM, the op latch and the registered strobes.

Test Plan:
- Reset asserted mid-WB_AL (add) → state = 000 immediately, RegWre = 0, no write. After release: IF then ID.
- add → state sequence 000, 001, 110, 111, 000.
  - RegWre high only in 111, RegDst = 10.
  - PCWre high only in 111.
- lw → 000, 001, 010, 011, 100, 000.
  - mRD = 1 in 011 only; RegWre = 1 in 100 only, DBDataSrc = 1, RegDst = 01.
- sw → same through 011, then back to 000 with mWR = 1 and PCWre = 1 in 011. RegWre stays 0 throughout.
- Branches, all 000 → 001 → 101 → 000:
  - beq with zero = 1 → PCSrc = 01 in 101.
  - beq with zero = 0 → PCSrc = 00.
  - bltz with sign = 1 → PCSrc = 01.
- Jumps and halt:
  - jal → 000 → 001 → 000; in 001, RegWre = 1, RegDst = 00, PCSrc = 11.
  - halt → stuck in 001 for 20 cycles with PCWre = 0.
  - op 101010 → Illegal pulse in 001, then back to 000.
